copro_result_buffer: RTL

Result stage directly downstream of the fixed-point MAC/LFSR coprocessor unit. It captures the unit's registered one-cycle result beat (result, hartid, id, rd, we), which arrives unconditionally with no backpressure, into a small ring FIFO. It presents the head entry on the CV-X-IF result valid/ready handshake toward the core. It also returns an issue-side credit (`issue_ready_o`) so the issue logic never launches an instruction whose result could find the buffer full.

---
 rtl/cvxif_instr_pkg.sv | 18 +
 rtl/copro_result_buffer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cvxif_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_instr_pkg
// Description : Shared constants and helpers for the coprocessor result path.
// Revision    : 1.0 - initial release
// ============================================================================
package cvxif_instr_pkg;

  // Default number of result buffer entries.
  localparam int unsigned CoproResultDepth = 4;

  // Pointer width for a power-of-two ring: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/copro_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : copro_result_buffer
// Description : Ring FIFO that captures coprocessor result beats and presents
//               them on the CV-X-IF result handshake, with an issue credit.
// Revision    : 1.0 - initial release
// ============================================================================
module copro_result_buffer
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned Depth    = CoproResultDepth,
  parameter type         hartid_t = logic,
  parameter type         id_t     = logic
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            issue_fire_i,
  output logic            issue_ready_o,
  input  logic            valid_i,
  input  logic [XLEN-1:0] result_i,
  input  hartid_t         hartid_i,
  input  id_t             id_i,
  input  logic [4:0]      rd_i,
  input  logic            we_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_data_o,
  output hartid_t         result_hartid_o,
  output id_t             result_id_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            overflow_o
);

  localparam int unsigned PW = ptr_width(Depth);
  localparam int unsigned IW = PW - 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(Depth);
  localparam logic [PW:0]   DEPTH_OCC = (PW + 1)'(Depth);

  typedef struct packed {
    logic [XLEN-1:0] data;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  entry_t        mem [Depth];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic          inflight_q;
  logic          overflow_q;

  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic [PW:0]   occupancy;
  entry_t        head;

  // Occupancy, handshake and credit decode from the registered pointers.
  always_comb begin
    count     = wptr_q - rptr_q;
    full      = (count == DEPTH_CNT);
    empty     = (count == '0);
    pop       = !empty && result_ready_i && !flush_i;
    // A full buffer still accepts a beat when the head leaves the same cycle.
    push      = valid_i && !flush_i && (!full || pop);
    occupancy = {1'b0, count} + {{PW{1'b0}}, inflight_q};
    head      = mem[rptr_q[IW-1:0]];
  end

  assign issue_ready_o   = (occupancy < DEPTH_OCC);
  assign result_valid_o  = !empty;
  assign result_data_o   = head.data;
  assign result_hartid_o = head.hartid;
  assign result_id_o     = head.id;
  assign result_rd_o     = head.rd;
  assign result_we_o     = head.we;
  assign overflow_o      = overflow_q;

  // Pointers, in-flight credit and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (valid_i && !flush_i && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (flush_i) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue_fire_i;
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  // Entry storage; cleared on reset so idle outputs read zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr_q[IW-1:0]] <= '{data: result_i, hartid: hartid_i, id: id_i,
                               rd: rd_i, we: we_i};
    end
  end

endmodule
`default_nettype wire
